// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage, req/ack data port, one WB pulse per instr.
// Define MEM_ACCESS_TIMEOUT_EN to abort accesses after 16 cycles.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  in_Ctrl,
  input  logic [31:0] in_ALUResult,
  input  logic [31:0] in_WriteData,
  input  logic [31:0] in_PC_4,
  input  logic [4:0]  in_WriteRegister,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_Stall,
  output logic        out_WB_Valid,
  output logic        out_WB_RegWrite,
  output logic [4:0]  out_WB_WriteRegister,
  output logic [31:0] out_WB_Data,
  output logic        out_MemError
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        vld_q, vld_d;
  logic        rw_q, rw_d;
  logic [4:0]  wr_q, wr_d;
  logic [31:0] data_q, data_d;

  logic        rd, wr, memop;
  logic        to_hit, to_fire;
  logic [31:0] wb_sel;

  assign rd    = in_Ctrl[1];
  assign wr    = in_Ctrl[2];
  assign memop = rd | wr;

  // memory data only for reads; stores and ALU ops keep the ALU result
  assign wb_sel = in_Ctrl[4] ? in_PC_4 :
                  ((in_Ctrl[3] & rd) ? mem_rdata : in_ALUResult);

  assign to_fire = (state_q == ACCESS) & ~mem_ack & to_hit;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  assign to_hit = (cnt_q == 4'hF);

  // timeout counter: cleared on issue, counts unacked ACCESS cycles
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | to_fire;
    if (state_q == IDLE && memop)
      cnt_d = 4'd0;
    else if (state_q == ACCESS && !mem_ack)
      cnt_d = cnt_q + 4'd1;
  end

  // timeout counter and sticky error register
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign out_MemError = err_q;
`else
  assign to_hit       = 1'b0;
  assign out_MemError = 1'b0;
`endif

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    vld_d   = vld_q;
    rw_d    = rw_q;
    wr_d    = wr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (memop) begin
          req_d   = 1'b1;
          we_d    = wr & ~rd;
          addr_d  = in_ALUResult;
          wdata_d = in_WriteData;
          vld_d   = 1'b0;
          state_d = ACCESS;
        end else begin
          vld_d  = 1'b1;
          rw_d   = in_Ctrl[0];
          wr_d   = in_WriteRegister;
          data_d = wb_sel;
        end
      end
      ACCESS: begin
        vld_d = 1'b0;
        if (mem_ack) begin
          req_d   = 1'b0;
          vld_d   = 1'b1;
          rw_d    = in_Ctrl[0];
          wr_d    = in_WriteRegister;
          data_d  = wb_sel;
          state_d = DONE;
        end else if (to_fire) begin
          req_d   = 1'b0;
          vld_d   = 1'b1;
          rw_d    = 1'b0;
          wr_d    = in_WriteRegister;
          data_d  = in_ALUResult;
          state_d = DONE;
        end
      end
      DONE: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        vld_d   = 1'b0;
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // stage registers, updated on the falling edge
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      vld_q   <= 1'b0;
      rw_q    <= 1'b0;
      wr_q    <= 5'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      vld_q   <= vld_d;
      rw_q    <= rw_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  assign mem_req              = req_q;
  assign mem_we               = we_q;
  assign mem_addr             = addr_q;
  assign mem_wdata            = wdata_q;
  assign out_WB_Valid         = vld_q;
  assign out_WB_RegWrite      = rw_q & vld_q;
  assign out_WB_WriteRegister = wr_q;
  assign out_WB_Data          = data_q;

  // stall while issuing or waiting; forced low during reset
  assign out_Stall = reset &
                     (((state_q == IDLE) & memop) | (state_q == ACCESS));

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: random instruction stream vs transaction model.
// Directed cases cover ALU, load, store, jal, read+write, reset, timeout.
module tb_mem_access_stage;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  in_Ctrl;
  logic [31:0] in_ALUResult;
  logic [31:0] in_WriteData;
  logic [31:0] in_PC_4;
  logic [4:0]  in_WriteRegister;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        out_Stall;
  logic        out_WB_Valid;
  logic        out_WB_RegWrite;
  logic [4:0]  out_WB_WriteRegister;
  logic [31:0] out_WB_Data;
  logic        out_MemError;

  int n_chk;
  int n_pass;
  logic exp_err;

  mem_access_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .in_Ctrl              (in_Ctrl),
    .in_ALUResult         (in_ALUResult),
    .in_WriteData         (in_WriteData),
    .in_PC_4              (in_PC_4),
    .in_WriteRegister     (in_WriteRegister),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .mem_ack              (mem_ack),
    .out_Stall            (out_Stall),
    .out_WB_Valid         (out_WB_Valid),
    .out_WB_RegWrite      (out_WB_RegWrite),
    .out_WB_WriteRegister (out_WB_WriteRegister),
    .out_WB_Data          (out_WB_Data),
    .out_MemError         (out_MemError)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Entered just after a rising edge; returns just after a rising edge.
  // lat = cycles mem_req is held before the acking edge.
  task automatic run_instr(input logic [4:0]  c,
                           input logic [31:0] alu,
                           input logic [31:0] wd,
                           input logic [31:0] pc4,
                           input logic [4:0]  wreg,
                           input int          lat,
                           input logic [31:0] rdat);
    logic        is_rd, is_wr, mop, tmo;
    logic [31:0] exp_d;
    int          nc;
    is_rd = c[1];
    is_wr = c[2];
    mop   = is_rd | is_wr;
    in_Ctrl          = c;
    in_ALUResult     = alu;
    in_WriteData     = wd;
    in_PC_4          = pc4;
    in_WriteRegister = wreg;
    mem_ack          = 1'($urandom);
    mem_rdata        = $urandom;
    #1;
    chk("stall_issue", 32'(out_Stall), 32'(mop));
    if (!mop) begin
      exp_d = c[4] ? pc4 : alu;
      @(negedge clk);
      @(posedge clk);
      mem_ack = 1'b0;
      chk("alu_vld", 32'(out_WB_Valid), 32'd1);
      chk("alu_rw", 32'(out_WB_RegWrite), 32'(c[0]));
      chk("alu_reg", 32'(out_WB_WriteRegister), 32'(wreg));
      chk("alu_data", out_WB_Data, exp_d);
      chk("alu_req", 32'(mem_req), 32'd0);
      chk("alu_err", 32'(out_MemError), 32'(exp_err));
    end else begin
      tmo = TO_EN && (lat > 16);
      nc  = tmo ? 16 : lat;
      @(negedge clk);
      @(posedge clk);
      chk("iss_req", 32'(mem_req), 32'd1);
      chk("iss_we", 32'(mem_we), 32'(is_wr & ~is_rd));
      chk("iss_addr", mem_addr, alu);
      chk("iss_wdata", mem_wdata, wd);
      chk("iss_vld", 32'(out_WB_Valid), 32'd0);
      for (int i = 1; i <= nc; i++) begin
        mem_ack   = (i == lat);
        mem_rdata = (i == lat) ? rdat : $urandom;
        if (i > 1) begin
          chk("acc_req", 32'(mem_req), 32'd1);
          chk("acc_addr", mem_addr, alu);
          chk("acc_vld", 32'(out_WB_Valid), 32'd0);
        end
        #1;
        chk("acc_stall", 32'(out_Stall), 32'd1);
        @(negedge clk);
        @(posedge clk);
      end
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
      #1;
      if (tmo) exp_err = 1'b1;
      exp_d = c[4] ? pc4 : ((c[3] & is_rd) ? rdat : alu);
      chk("ret_req", 32'(mem_req), 32'd0);
      chk("ret_vld", 32'(out_WB_Valid), 32'd1);
      chk("ret_rw", 32'(out_WB_RegWrite), tmo ? 32'd0 : 32'(c[0]));
      chk("ret_stall", 32'(out_Stall), 32'd0);
      chk("ret_err", 32'(out_MemError), 32'(exp_err));
      if (!tmo) begin
        chk("ret_reg", 32'(out_WB_WriteRegister), 32'(wreg));
        chk("ret_data", out_WB_Data, exp_d);
      end
      @(negedge clk);
      @(posedge clk);
      mem_ack = 1'b0;
      chk("done_vld", 32'(out_WB_Valid), 32'd0);
      chk("done_req", 32'(mem_req), 32'd0);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_stall"}, 32'(out_Stall), 32'd0);
    chk({tag, "_vld"}, 32'(out_WB_Valid), 32'd0);
    chk({tag, "_rw"}, 32'(out_WB_RegWrite), 32'd0);
    chk({tag, "_data"}, out_WB_Data, 32'd0);
    chk({tag, "_err"}, 32'(out_MemError), 32'd0);
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    exp_err = 1'b0;
    reset            = 1'b0;
    in_Ctrl          = 5'b00010;
    in_ALUResult     = 32'h44;
    in_WriteData     = 32'd0;
    in_PC_4          = 32'd0;
    in_WriteRegister = 5'd0;
    mem_rdata        = 32'd0;
    mem_ack          = 1'b0;
    #1;
    chk_reset_outs("rst0");
    repeat (2) @(posedge clk);
    reset   = 1'b1;
    in_Ctrl = 5'b00000;

    run_instr(5'b00001, 32'h10, 32'h0, 32'h0, 5'd3, 1, 32'h0);
    run_instr(5'b01011, 32'h40, 32'h0, 32'h0, 5'd7, 3, 32'hCAFEF00D);
    run_instr(5'b00100, 32'h80, 32'h12345678, 32'h0, 5'd0, 2, 32'h0);
    run_instr(5'b10001, 32'h5, 32'h0, 32'h400004, 5'd1, 1, 32'h0);
    run_instr(5'b00111, 32'hC0, 32'hDEAD, 32'h0, 5'd9, 2, 32'h99);
    run_instr(5'b01011, 32'h100, 32'h0, 32'h0, 5'd4, 16, 32'hABCD1234);
    run_instr(5'b00001, 32'h20, 32'h0, 32'h0, 5'd5, 1, 32'h0);

    // reset in the middle of an access
    in_Ctrl      = 5'b01011;
    in_ALUResult = 32'h200;
    mem_ack      = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    exp_err = 1'b0;
    chk_reset_outs("rstA");
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555;
    @(negedge clk);
    @(posedge clk);
    chk_reset_outs("rstB");
    mem_ack = 1'b0;
    in_Ctrl = 5'b00000;
    reset   = 1'b1;
    @(negedge clk);
    @(posedge clk);
    chk("post_rst_req", 32'(mem_req), 32'd0);
    chk("post_rst_rw", 32'(out_WB_RegWrite), 32'd0);

    // no ack for 20 cycles: timeout when enabled, else ack at 20
    run_instr(5'b01011, 32'h300, 32'h0, 32'h0, 5'd6, 20, 32'h77);
    run_instr(5'b00001, 32'h30, 32'h0, 32'h0, 5'd8, 1, 32'h0);

    for (int k = 0; k < 150; k++) begin
      run_instr(5'($urandom), $urandom, $urandom, $urandom,
                5'($urandom), $urandom_range(1, 6), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
REQ-002 clk  in  1  clock; all state updates on the falling edge, matching the pipeline registers.
REQ-003 reset  in  1  reset, asynchronous, active-low.
REQ-004 in_Ctrl  in  5  EX/MEM control bits: [0] RegWrite, [1] MemRead, [2] MemWrite, [3] ALUOrMem, [4] ALUMemOrPC.
REQ-005 in_ALUResult  in  32  ALU result; this is the memory address for loads and stores.
REQ-006 in_WriteData  in  32  store data.
REQ-007 in_PC_4  in  32  PC+4, the link value.
REQ-008 in_WriteRegister  in  5  destination register.
REQ-009 mem_req  out  1  data-memory request, held until acknowledged.
REQ-010 mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
REQ-011 mem_addr  out  32  latched address.
REQ-012 mem_wdata  out  32  latched store data.
REQ-013 mem_rdata  in  32  read data; valid in the mem_ack cycle.
REQ-014 mem_ack  in  1  memory completion strobe.
REQ-015 out_Stall  out  1  freezes EX/MEM and all earlier stages.
REQ-016 out_WB_Valid  out  1  one-cycle retire strobe into MEM/WB.
REQ-017 out_WB_RegWrite  out  1  register-file write enable, gated by out_WB_Valid.
REQ-018 out_WB_WriteRegister  out  5  registered destination register.
REQ-019 out_WB_Data  out  32  registered write-back value.
REQ-020 out_MemError  out  1  sticky memory-timeout flag.

Function
REQ-021 SHALL implement a three-state FSM: IDLE, ACCESS, DONE.
REQ-022 memop = MemRead | MemWrite; when both are set, the access SHALL be a read with no write issued.
REQ-023 IDLE with no memop: at the edge, latch WB outputs and set out_WB_Valid=1; latency 1 cycle.
REQ-024 IDLE with memop: at the edge, set mem_req=1, mem_we=(MemWrite & ~MemRead), latch mem_addr and mem_wdata, set out_WB_Valid=0, go to ACCESS.
REQ-025 ACCESS: mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until mem_ack is sampled high at an edge.
REQ-026 ACCESS with mem_ack=1: drop mem_req, capture the WB result, set out_WB_Valid=1, go to DONE.
REQ-027 ACCESS with mem_ack=0: remain in ACCESS with out_WB_Valid=0.
REQ-028 mem_ack SHALL be ignored in IDLE and DONE.
REQ-029 DONE: at the next edge, set out_WB_Valid=0 and go to IDLE; upstream advances on the same edge.
REQ-030 out_Stall (combinational) = (IDLE & memop) | ACCESS; it SHALL be 0 in DONE.
REQ-031 WB data select: ALUMemOrPC ? in_PC_4 : (ALUOrMem ? captured mem_rdata : in_ALUResult); store results SHALL use in_ALUResult.
REQ-032 out_WB_RegWrite SHALL be RegWrite & out_WB_Valid, and 0 for a squashed access.
REQ-033 Each instruction SHALL produce exactly one out_WB_Valid pulse; DONE prevents re-issue of the held memop.

Reset
REQ-034 On reset low, SHALL go to IDLE immediately, regardless of clk.
REQ-035 On reset low, every output SHALL be 0, including mem_req mid-access.
REQ-036 On reset low, the timeout counter and out_MemError SHALL clear.
REQ-037 An access interrupted by reset SHALL NOT be resumed or retired.

Configuration
REQ-038 Macro MEM_ACCESS_TIMEOUT_EN defined: a 4-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-039 With MEM_ACCESS_TIMEOUT_EN, after 16 ACCESS cycles without ack: drop mem_req, set out_MemError=1 (sticky until reset), go to DONE with out_WB_Valid=1 and out_WB_RegWrite=0.
REQ-040 With MEM_ACCESS_TIMEOUT_EN, an ack in the 16th cycle SHALL win over the timeout.
REQ-041 Macro undefined: ACCESS waits indefinitely, no counter is present, and out_MemError is tied to 0.

Verification
REQ-042 ALU op, in_Ctrl=5'b00001, ALUResult=0x10 -> one edge later WB_Valid=1, WB_Data=0x10, RegWrite=1, Stall never asserted.
REQ-043 Load, Ctrl=5'b01011, ALUResult=0x40, ack after 3 cycles with rdata=0xCAFEF00D -> mem_req held 3 cycles at addr 0x40, we=0; WB_Data=0xCAFEF00D; Stall high until the ack edge.
REQ-044 Store, Ctrl=5'b00100, WriteData=0x12345678 -> mem_we=1, wdata=0x12345678; one WB_Valid pulse with RegWrite=0.
REQ-045 jal, Ctrl=5'b10001, PC_4=0x400004 -> WB_Data=0x400004; MemRead and MemWrite both set -> read issued only.
REQ-046 Reset pulse low during ACCESS -> mem_req=0 asynchronously, no WB_Valid pulse; with timeout enabled and no ack, MemError=1 after 16 ACCESS cycles, with one WB_Valid pulse and RegWrite=0.
